// File: rtl/cmp_pkg.sv
// Shared types for the pipelined compare unit: op encodings and the result record
// held in the output/skid storage slots.
package cmp_pkg;

    localparam int CMP_OP_W     = 4;
    // Storage records are sized for the widest supported configuration.
    localparam int CMP_XLEN_MAX = 64;
    localparam int CMP_TAG_MAX  = 16;

    localparam logic [CMP_OP_W-1:0] CMP_ENC_SLT  = 4'd0;
    localparam logic [CMP_OP_W-1:0] CMP_ENC_SLTU = 4'd1;
    localparam logic [CMP_OP_W-1:0] CMP_ENC_EQ   = 4'd2;
    localparam logic [CMP_OP_W-1:0] CMP_ENC_NE   = 4'd3;
    localparam logic [CMP_OP_W-1:0] CMP_ENC_LT   = 4'd4;
    localparam logic [CMP_OP_W-1:0] CMP_ENC_GE   = 4'd5;
    localparam logic [CMP_OP_W-1:0] CMP_ENC_LTU  = 4'd6;
    localparam logic [CMP_OP_W-1:0] CMP_ENC_GEU  = 4'd7;
    localparam logic [CMP_OP_W-1:0] CMP_ENC_MIN  = 4'd8;
    localparam logic [CMP_OP_W-1:0] CMP_ENC_MAX  = 4'd9;
    localparam logic [CMP_OP_W-1:0] CMP_ENC_MINU = 4'd10;
    localparam logic [CMP_OP_W-1:0] CMP_ENC_MAXU = 4'd11;

    typedef enum logic [CMP_OP_W-1:0] {
        CMP_SLT  = CMP_ENC_SLT,
        CMP_SLTU = CMP_ENC_SLTU,
        CMP_EQ   = CMP_ENC_EQ,
        CMP_NE   = CMP_ENC_NE,
        CMP_LT   = CMP_ENC_LT,
        CMP_GE   = CMP_ENC_GE,
        CMP_LTU  = CMP_ENC_LTU,
        CMP_GEU  = CMP_ENC_GEU,
        CMP_MIN  = CMP_ENC_MIN,
        CMP_MAX  = CMP_ENC_MAX,
        CMP_MINU = CMP_ENC_MINU,
        CMP_MAXU = CMP_ENC_MAXU
    } cmp_op_t;

    typedef struct packed {
        logic [CMP_XLEN_MAX-1:0] result;
        logic                    taken;
        logic [CMP_TAG_MAX-1:0]  tag;
        logic                    illegal;
    } cmp_res_t;

endpackage

// File: rtl/cmp_unit_pipe_if.sv
// Issue-side and result-side handshake bundle of the compare unit.
// master = issue/consumer side, slave = the compare unit.
interface cmp_unit_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [3:0]       op_i;
    logic [XLEN-1:0]  rs1_i;
    logic [XLEN-1:0]  rs2_i;
    logic [TAG_W-1:0] tag_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [XLEN-1:0]  result_o;
    logic             taken_o;
    logic [TAG_W-1:0] tag_o;
    logic             illegal_o;

    modport master (
        output in_valid_i, op_i, rs1_i, rs2_i, tag_i, out_ready_i,
        input  in_ready_o, out_valid_o, result_o, taken_o, tag_o, illegal_o
    );

    modport slave (
        input  in_valid_i, op_i, rs1_i, rs2_i, tag_i, out_ready_i,
        output in_ready_o, out_valid_o, result_o, taken_o, tag_o, illegal_o
    );
endinterface

// File: rtl/cmp_skid_buf.sv
// Two-entry FIFO storage (output register + skid slot) for compare results, with flush.
// in_ready_o comes straight from a flop so the consumer's ready never reaches the producer.
module cmp_skid_buf
    import cmp_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     flush_i,
    input  logic     push_i,
    input  cmp_res_t push_res_i,
    input  logic     pop_ready_i,
    output logic     in_ready_o,
    output logic     out_valid_o,
    output cmp_res_t out_res_o
);

    logic     out_vld_q, out_vld_d;
    logic     skid_vld_q, skid_vld_d;
    cmp_res_t out_res_q, out_res_d;
    cmp_res_t skid_res_q, skid_res_d;
    logic     slot_free;

    assign slot_free = !out_vld_q || pop_ready_i;

    always_comb begin
        out_vld_d  = out_vld_q;
        out_res_d  = out_res_q;
        skid_vld_d = skid_vld_q;
        skid_res_d = skid_res_q;
        if (flush_i) begin
            out_vld_d  = 1'b0;
            skid_vld_d = 1'b0;
        end else if (slot_free) begin
            // The older skid entry always refills the output before a new one.
            if (skid_vld_q) begin
                out_vld_d  = 1'b1;
                out_res_d  = skid_res_q;
                skid_vld_d = push_i;
                if (push_i) begin
                    skid_res_d = push_res_i;
                end
            end else begin
                out_vld_d = push_i;
                if (push_i) begin
                    out_res_d = push_res_i;
                end
            end
        end else if (push_i) begin
            skid_vld_d = 1'b1;
            skid_res_d = push_res_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q  <= 1'b0;
            skid_vld_q <= 1'b0;
            out_res_q  <= '0;
            skid_res_q <= '0;
        end else begin
            out_vld_q  <= out_vld_d;
            skid_vld_q <= skid_vld_d;
            out_res_q  <= out_res_d;
            skid_res_q <= skid_res_d;
        end
    end

    assign in_ready_o  = !skid_vld_q;
    assign out_valid_o = out_vld_q;
    assign out_res_o   = out_res_q;

endmodule

// File: rtl/cmp_unit_pipe.sv
// Pipelined SLT/branch compare unit: combinational compare feeding a 2-entry result buffer.
// Define CMP_ZBB_MINMAX_EN to add MIN/MAX/MINU/MAXU; otherwise those encodings are illegal.
module cmp_unit_pipe
    import cmp_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    cmp_unit_pipe_if.slave bus
);

    cmp_op_t                op;
    logic signed [XLEN-1:0] rs1_s;
    logic signed [XLEN-1:0] rs2_s;
    logic                   lt_s;
    logic                   lt_u;
    logic                   eq;
    cmp_res_t               cmp_res;
    cmp_res_t               out_res;
    logic                   in_ready;
    logic                   out_valid;
    logic                   push;

    assign op    = cmp_op_t'(bus.op_i);
    assign rs1_s = bus.rs1_i;
    assign rs2_s = bus.rs2_i;
    assign lt_s  = rs1_s < rs2_s;
    assign lt_u  = bus.rs1_i < bus.rs2_i;
    assign eq    = bus.rs1_i == bus.rs2_i;

    always_comb begin
        cmp_res = '0;
        cmp_res.tag[TAG_W-1:0] = bus.tag_i;
        case (op)
            CMP_SLT:  cmp_res.result[0] = lt_s;
            CMP_SLTU: cmp_res.result[0] = lt_u;
            CMP_EQ:   cmp_res.taken     = eq;
            CMP_NE:   cmp_res.taken     = !eq;
            CMP_LT:   cmp_res.taken     = lt_s;
            CMP_GE:   cmp_res.taken     = !lt_s;
            CMP_LTU:  cmp_res.taken     = lt_u;
            CMP_GEU:  cmp_res.taken     = !lt_u;
`ifdef CMP_ZBB_MINMAX_EN
            CMP_MIN:  cmp_res.result[XLEN-1:0] = lt_s ? bus.rs1_i : bus.rs2_i;
            CMP_MAX:  cmp_res.result[XLEN-1:0] = lt_s ? bus.rs2_i : bus.rs1_i;
            CMP_MINU: cmp_res.result[XLEN-1:0] = lt_u ? bus.rs1_i : bus.rs2_i;
            CMP_MAXU: cmp_res.result[XLEN-1:0] = lt_u ? bus.rs2_i : bus.rs1_i;
`else
            CMP_MIN, CMP_MAX, CMP_MINU, CMP_MAXU: cmp_res.illegal = 1'b1;
`endif
            default:  cmp_res.illegal = 1'b1;
        endcase
    end

    // Flush wins over a same-cycle accept inside the buffer, so push needs no flush gating.
    assign push = bus.in_valid_i && in_ready;

    cmp_skid_buf u_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush_i),
        .push_i      (push),
        .push_res_i  (cmp_res),
        .pop_ready_i (bus.out_ready_i),
        .in_ready_o  (in_ready),
        .out_valid_o (out_valid),
        .out_res_o   (out_res)
    );

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = out_valid;
    assign bus.result_o    = out_res.result[XLEN-1:0];
    assign bus.taken_o     = out_res.taken;
    assign bus.tag_o       = out_res.tag[TAG_W-1:0];
    assign bus.illegal_o   = out_res.illegal;

    // Records are max-width; the bits above XLEN/TAG_W are always zero here.
    logic unused_res_bits;
    assign unused_res_bits = ^{out_res.result, out_res.tag};

endmodule
